sub4b_serial: RTL and testbench



---
 rtl/sub4b_serial_pkg.sv | 15 +
 rtl/sub4b_serial_sub1bcc.sv | 16 +
 rtl/sub4b_serial.sv | 115 +++++++++++
 tb/tb_sub4b_serial.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sub4b_serial_pkg.sv
// sub4b_serial_pkg: shared state encoding and default width for the
// bit-serial subtractor and its 1-bit cell.
// Ports: none (package only).
package sub4b_serial_pkg;

  // Default operand/result width
  localparam int NB_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : sub4b_serial_pkg

// File: rtl/sub4b_serial_sub1bcc.sv
// sub1bcc: combinational 1-bit full subtractor (A - B - Bi_in).
// Ports: A, B, Bi_in (borrow in) -> D (difference bit), Bout (borrow out).
// Counterpart of the lab's 1-bit full-adder cell; no state, zero latency.
module sub1bcc (
  input  logic A,
  input  logic B,
  input  logic Bi_in,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bi_in;
  // Borrow when B exceeds A, or when A==B and a borrow is already pending
  assign Bout = (~A & B) | (~(A ^ B) & Bi_in);

endmodule : sub1bcc

// File: rtl/sub4b_serial.sv
// sub4b_serial: bit-serial unsigned subtractor Ai - Bi, LSB first, one bit per clock.
// Ports: clk, rst_n (async active-low), start, Ai, Bi in; busy, done, Di_n, Bo_n out.
// Latency nb+1 cycles to done; start is ignored while busy. Di_n/Bo_n are active-low LED drives.
module sub4b_serial
  import sub4b_serial_pkg::*;
#(
  parameter int nb = NB_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [nb-1:0] Ai,
  input  logic [nb-1:0] Bi,
  output logic          busy,
  output logic          done,
  output logic [nb-1:0] Di_n,
  output logic          Bo_n
);

  localparam int            CW       = (nb > 1) ? $clog2(nb) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(nb - 1);

  state_e          state_q, state_d;
  logic [nb-1:0]   a_sr_q, a_sr_d;
  logic [nb-1:0]   b_sr_q, b_sr_d;
  logic [nb-1:0]   res_q, res_d;
  logic [nb-1:0]   di_n_q, di_n_d;
  logic            br_q, br_d;
  logic            bo_n_q, bo_n_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            cell_d;
  logic            cell_bout;
  logic [nb-1:0]   res_shift;

  // Single shared cell: operates on the current LSBs and the stored borrow
  sub1bcc u_cell (
    .A     (a_sr_q[0]),
    .B     (b_sr_q[0]),
    .Bi_in (br_q),
    .D     (cell_d),
    .Bout  (cell_bout)
  );

  // Result fills from the MSB side so the LSB-first bits land in place after nb shifts
  assign res_shift = {cell_d, res_q[nb-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    di_n_d  = di_n_q;
    bo_n_d  = bo_n_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = Ai;
          b_sr_d  = Bi;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d = {1'b0, a_sr_q[nb-1:1]};
        b_sr_d = {1'b0, b_sr_q[nb-1:1]};
        res_d  = res_shift;
        br_d   = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        // Outputs only update on the final bit, so they hold steady during RUN
        if (cnt_q == CNT_LAST) begin
          di_n_d  = ~res_shift;
          bo_n_d  = ~cell_bout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      di_n_q  <= '1;
      bo_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      di_n_q  <= di_n_d;
      bo_n_q  <= bo_n_d;
    end
  end

  // Decoded straight from the state register, so reset clears them immediately
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign Di_n = di_n_q;
  assign Bo_n = bo_n_q;

endmodule : sub4b_serial

// File: tb/tb_sub4b_serial.sv
// tb_sub4b_serial: directed self-checking bench for the bit-serial subtractor.
// Drives inputs and samples outputs on the falling edge, away from the active edge.
// Expected values are hand-computed constants.
module tb_sub4b_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] Ai;
  logic [3:0] Bi;
  logic       busy;
  logic       done;
  logic [3:0] Di_n;
  logic       Bo_n;

  int n_checks = 0;
  int n_pass   = 0;

  sub4b_serial #(.nb(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Ai    (Ai),
    .Bi    (Bi),
    .busy  (busy),
    .done  (done),
    .Di_n  (Di_n),
    .Bo_n  (Bo_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Launch one operation and watch it for 12 falling edges after the accepting edge.
  // When chg is set the operands are scrambled before E2; the result must not change.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_di, input logic exp_bo, input bit chg);
    int done_at;
    int busy_cnt;
    int ndone;
    done_at  = 0;
    busy_cnt = 0;
    ndone    = 0;
    @(negedge clk);
    Ai = a; Bi = b; start = 1'b1;
    @(negedge clk);   // first falling edge after the accepting edge E0
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      if (chg && k == 2) begin
        Ai = ~a; Bi = ~b;
      end
      if (k < 12) @(negedge clk);
    end
    chk({tag, " done_cycle"}, 32'(done_at), 32'd5);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd5);
    chk({tag, " done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, " Di_n"}, 32'(Di_n), 32'(exp_di));
    chk({tag, " Bo_n"}, 32'(Bo_n), 32'(exp_bo));
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    Ai    = 4'd0;
    Bi    = 4'd0;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset Di_n", 32'(Di_n), 32'hF);
    chk("reset Bo_n", 32'(Bo_n), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("9-3",   4'd9,  4'd3,  4'b1001, 1'b1, 1'b0);
    run_op("3-9",   4'd3,  4'd9,  4'b0101, 1'b0, 1'b0);
    run_op("0-0",   4'd0,  4'd0,  4'b1111, 1'b1, 1'b0);
    run_op("15-15", 4'd15, 4'd15, 4'b1111, 1'b1, 1'b0);
    run_op("0-1",   4'd0,  4'd1,  4'b0000, 1'b0, 1'b0);

    // Busy-start rejection: 12-5, extra starts during RUN and DONE
    ndone = 0;
    @(negedge clk);
    Ai = 4'd12; Bi = 4'd5; start = 1'b1;
    @(negedge clk);                 // n1
    start = 1'b0;
    @(negedge clk);                 // n2: start sampled at E2 while RUN
    Ai = 4'd1; Bi = 4'd1; start = 1'b1;
    @(negedge clk);                 // n3
    start = 1'b0;
    chk("rej Di_n hold in RUN", 32'(Di_n), 32'h0);  // still holds 0-1 result
    @(negedge clk);                 // n4
    if (done) ndone++;
    @(negedge clk);                 // n5: DONE cycle; start sampled at E5 must be ignored
    if (done) ndone++;
    chk("rej done in DONE", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);                 // n6: must be IDLE
    if (done) ndone++;
    chk("rej busy after DONE", 32'(busy), 32'd0);
    chk("rej done pulses", 32'(ndone), 32'd1);
    chk("rej Di_n", 32'(Di_n), 32'h8);
    chk("rej Bo_n", 32'(Bo_n), 32'd1);
    @(negedge clk);                 // n7: start held through E6 is accepted
    start = 1'b0;
    chk("next start accepted", 32'(busy), 32'd1);
    chk("next Di_n hold", 32'(Di_n), 32'h8);
    repeat (6) @(negedge clk);
    chk("next 1-1 Di_n", 32'(Di_n), 32'hF);
    chk("next 1-1 busy", 32'(busy), 32'd0);

    run_op("9-3 chg", 4'd9, 4'd3, 4'b1001, 1'b1, 1'b1);

    // Reset mid-operation at E2 of 6-2
    @(negedge clk);
    Ai = 4'd6; Bi = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                 // E1
    @(posedge clk);                 // E2
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst Di_n", 32'(Di_n), 32'hF);
    chk("midrst Bo_n", 32'(Bo_n), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst no done", 32'(ndone), 32'd0);
    chk("midrst idle", 32'(busy), 32'd0);

    run_op("6-2", 4'd6, 4'd2, 4'b1011, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sub4b_serial
